// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: state encodings, zero payload and control polarities shared by pipe_stage_reg.
package pipe_stage_reg_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;
  localparam int MAX_PL_W = 1024;
  localparam logic [MAX_PL_W-1:0] ZERO_PAYLOAD = '0;
  localparam logic RST_ON = 1'b1;
  localparam logic FLUSH_ON = 1'b1;
endpackage

// File: rtl/pipe_stage_reg_sat_cnt.sv
// pipe_sat_cnt: W-bit saturating up-counter with enable and asynchronous active-high reset.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int SIDE_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [PC_W-1:0]   up_pc,
  input  logic [INST_W-1:0] up_inst,
  input  logic [SIDE_W-1:0] up_side,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [PC_W-1:0]   dn_pc,
  output logic [INST_W-1:0] dn_inst,
  output logic [SIDE_W-1:0] dn_side
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);
  localparam int PL_W = PC_W + INST_W + SIDE_W;
  localparam logic [PL_W-1:0] ZERO = ZERO_PAYLOAD[PL_W-1:0];
  state_t state, state_nx;
  logic [PL_W-1:0] out_q, skid_q, out_nx, skid_nx, up_pl;
  assign up_pl = {up_side, up_pc, up_inst};
  assign up_ready = state != ST_FULL;
  assign dn_valid = state != ST_EMPTY;
  // out is kept zero whenever the stage is empty, so outputs need no masking
  assign {dn_side, dn_pc, dn_inst} = out_q;
  always_comb begin
    state_nx = state;
    out_nx = out_q;
    skid_nx = skid_q;
    if (flush == FLUSH_ON) begin
      state_nx = ST_EMPTY;
      out_nx = ZERO;
      skid_nx = ZERO;
    end else if (state == ST_EMPTY) begin
      if (up_valid) begin
        out_nx = up_pl;
        state_nx = ST_ONE;
      end
    end else if (state == ST_ONE) begin
      if (up_valid && dn_ready) out_nx = up_pl;
      else if (up_valid) begin
        skid_nx = up_pl;
        state_nx = ST_FULL;
      end else if (dn_ready) begin
        out_nx = ZERO;
        state_nx = ST_EMPTY;
      end
    end else if (state == ST_FULL) begin
      if (dn_ready) begin
        out_nx = skid_q;
        skid_nx = ZERO;
        state_nx = ST_ONE;
      end
    end else begin
      state_nx = ST_EMPTY;
      out_nx = ZERO;
      skid_nx = ZERO;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_EMPTY;
      out_q <= ZERO;
      skid_q <= ZERO;
    end else begin
      state <= state_nx;
      out_q <= out_nx;
      skid_q <= skid_nx;
    end
`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt #(.W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .en(dn_valid && !dn_ready), .cnt(stall_cnt)
  );
  pipe_sat_cnt #(.W(CNT_W)) u_bubble (
    .clk(clk), .rst(rst), .en(!dn_valid), .cnt(bubble_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table plus randomized run against a 2-deep FIFO queue model.
module tb_pipe_stage_reg;
  localparam int PC_W = 32, INST_W = 32, SIDE_W = 1, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst, flush, up_valid, up_ready, dn_valid, dn_ready;
  logic [PC_W-1:0] up_pc, dn_pc;
  logic [INST_W-1:0] up_inst, dn_inst;
  logic [SIDE_W-1:0] up_side, dn_side;
  int n = 0, errs = 0;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  int m_stall = 0, m_bubble = 0;
`endif
  typedef struct packed {
    logic [SIDE_W-1:0] side;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ent_t;
  ent_t q[$];
  typedef struct {
    logic v; logic [31:0] pc; logic s, r, f;
    logic ev; logic [31:0] epc; logic es, erdy;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  pipe_stage_reg #(.PC_W(PC_W), .INST_W(INST_W), .SIDE_W(SIDE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc), .up_inst(up_inst), .up_side(up_side),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_pc(dn_pc), .dn_inst(dn_inst), .dn_side(dn_side)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc * 3 + 32'h13;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] pc, input logic s, input logic r, input logic f);
    ent_t e;
    logic acc;
    up_valid = v; up_pc = pc; up_inst = inst_of(pc); up_side = s; dn_ready = r; flush = f;
`ifdef PIPE_STAGE_PERF_EN
    if (q.size() != 0 && !r && m_stall < CMAX) m_stall++;
    if (q.size() == 0 && m_bubble < CMAX) m_bubble++;
`endif
    acc = v && q.size() < 2;
    if (f) q.delete();
    else begin
      if (q.size() != 0 && r) void'(q.pop_front());
      if (acc) q.push_back('{s, pc, inst_of(pc)});
    end
    @(posedge clk);
    #1;
    e = q.size() != 0 ? q[0] : '0;
    chk("model", {dn_valid, up_ready, dn_side, dn_pc, dn_inst},
        {q.size() != 0, q.size() < 2, e.side, e.pc, e.inst});
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
  endtask
  task automatic reset_seq();
    up_valid = 1'b1; up_pc = 32'h100; up_inst = inst_of(32'h100); up_side = '1;
    dn_ready = 1'b1; flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async", {dn_valid, up_ready, dn_side, dn_pc, dn_inst}, {1'b0, 1'b1, 65'd0});
    q.delete();
`ifdef PIPE_STAGE_PERF_EN
    m_stall = 0; m_bubble = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {dn_valid, up_ready, dn_side, dn_pc, dn_inst}, {1'b0, 1'b1, 65'd0});
    @(negedge clk);
    rst = 1'b0;
    up_valid = 1'b0;
    step(0, 32'h0, 0, 1, 0);
  endtask
  initial begin
    rst = 1'b0; flush = 1'b0; up_valid = 1'b0; up_pc = '0; up_inst = '0; up_side = '0; dn_ready = 1'b1;
    #2;
    reset_seq();
    for (int i = 0; i < 8; i++) tbl.push_back('{1, 4 * i, 0, 1, 0, 1, 4 * i, 0, 1});
    tbl.push_back('{1, 'h20, 0, 0, 0, 1, 'h1C, 0, 0});
    tbl.push_back('{1, 'h24, 0, 0, 0, 1, 'h1C, 0, 0});
    tbl.push_back('{1, 'h24, 0, 0, 0, 1, 'h1C, 0, 0});
    tbl.push_back('{1, 'h24, 0, 1, 0, 1, 'h20, 0, 1});
    tbl.push_back('{1, 'h24, 0, 1, 0, 1, 'h24, 0, 1});
    tbl.push_back('{0, 'h0,  0, 1, 0, 0, 'h0,  0, 1});
    tbl.push_back('{1, 'h8,  1, 0, 0, 1, 'h8,  1, 1});
    tbl.push_back('{1, 'hC,  0, 0, 0, 1, 'h8,  1, 0});
    tbl.push_back('{0, 'h0,  0, 1, 0, 1, 'hC,  0, 1});
    tbl.push_back('{0, 'h0,  0, 1, 0, 0, 'h0,  0, 1});
    tbl.push_back('{1, 'h30, 0, 0, 0, 1, 'h30, 0, 1});
    tbl.push_back('{1, 'h34, 0, 0, 0, 1, 'h30, 0, 0});
    tbl.push_back('{1, 'h38, 0, 0, 0, 1, 'h30, 0, 0});
    tbl.push_back('{1, 'h40, 0, 1, 1, 0, 'h0,  0, 1});
    tbl.push_back('{0, 'h0,  0, 1, 0, 0, 'h0,  0, 1});
    tbl.push_back('{1, 'h44, 0, 0, 0, 1, 'h44, 0, 1});
    tbl.push_back('{1, 'h48, 0, 0, 1, 0, 'h0,  0, 1});
    tbl.push_back('{0, 'h0,  0, 1, 0, 0, 'h0,  0, 1});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].s, tbl[i].r, tbl[i].f);
      chk($sformatf("vec%0d", i), {dn_valid, up_ready, dn_side, dn_pc, dn_inst},
          {tbl[i].ev, tbl[i].erdy, tbl[i].es, tbl[i].epc, tbl[i].ev ? inst_of(tbl[i].epc) : 32'h0});
`ifdef PIPE_STAGE_PERF_EN
      if (i == 10) chk("stall3", stall_cnt, 3);
`endif
    end
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    step(1, 32'h50, 0, 0, 0);
    step(1, 32'h54, 0, 0, 0);
    step(1, 32'h58, 0, 0, 0);
    #2;
    reset_seq();
    for (int i = 0; i < 20; i++) step(0, 32'h0, 0, 1, 0);
`ifdef PIPE_STAGE_PERF_EN
    chk("bubble_sat", bubble_cnt, 15);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
